// File: rtl/button_conditioner.sv
// button_conditioner: per-button synchronizer, debouncer, press/release pulses and step output.
// Define BTN_AUTOREPEAT_EN to add long-press auto-repeat (repeat FSM, long_hold).
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] but_n,
  output logic [1:0] pressed,
  output logic [1:0] press_pulse,
  output logic [1:0] release_pulse,
  output logic [1:0] step,
  output logic [1:0] long_hold
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
`endif
  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic s1, s2, raw, hit, acc_press, acc_release, fire;
    logic prs, pp, rp, st, lh;
    logic [DW-1:0] deb_cnt;
    assign raw = ~s2;
    assign hit = (raw != prs) && (deb_cnt == DW'(DEBOUNCE_CYCLES - 1));
    assign acc_press = hit & raw;
    assign acc_release = hit & ~raw;
    assign pressed[i] = prs;
    assign press_pulse[i] = pp;
    assign release_pulse[i] = rp;
    assign step[i] = st;
    assign long_hold[i] = lh;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1 <= 1'b1;
        s2 <= 1'b1;
        deb_cnt <= '0;
        prs <= 1'b0;
        pp <= 1'b0;
        rp <= 1'b0;
        st <= 1'b0;
      end else begin
        s1 <= but_n[i];
        s2 <= s1;
        deb_cnt <= (raw == prs || hit) ? '0 : deb_cnt + 1'b1;
        prs <= prs ^ hit;
        pp <= acc_press;
        rp <= acc_release;
        st <= acc_press | fire;
      end
    end
`ifdef BTN_AUTOREPEAT_EN
    state_t state, state_n;
    logic [RW-1:0] rep_cnt, rep_cnt_n;
    logic hold_n;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= IDLE;
        rep_cnt <= '0;
        lh <= 1'b0;
      end else begin
        state <= state_n;
        rep_cnt <= rep_cnt_n;
        lh <= hold_n;
      end
    end
    // Release wins over a repeat falling on the same cycle.
    always_comb begin
      state_n = state;
      rep_cnt_n = rep_cnt + 1'b1;
      hold_n = lh;
      fire = 1'b0;
      if (acc_release) begin
        state_n = IDLE;
        rep_cnt_n = '0;
        hold_n = 1'b0;
      end else if (state == IDLE) begin
        rep_cnt_n = '0;
        state_n = acc_press ? DELAY : IDLE;
      end else if (state == DELAY && rep_cnt == RW'(REPEAT_DELAY - 1)) begin
        fire = 1'b1;
        hold_n = 1'b1;
        rep_cnt_n = '0;
        state_n = REPEAT;
      end else if (state == REPEAT && rep_cnt == RW'(REPEAT_PERIOD - 1)) begin
        fire = 1'b1;
        rep_cnt_n = '0;
      end
    end
`else
    assign fire = 1'b0;
    assign lh = 1'b0;
`endif
  end
endmodule
